// File: rtl/sine_voice_scheduler.sv
// Shares one registered quarter-wave sine table among VOICES phase accumulators,
// issuing one table address per cycle and summing the rebuilt samples per frame.
module sine_voice_scheduler #(
    parameter int VOICES  = 4,
    parameter int N       = 7,
    parameter int PHASE_W = 16,
    localparam int VW     = $clog2(VOICES),
    localparam int MW     = N + 1 + VW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               cfg_we,
    input  logic [VW-1:0]      cfg_voice,
    input  logic               cfg_en,
    input  logic [PHASE_W-1:0] cfg_inc,
    output logic [N:0]         lut_addr,
    input  logic [N-1:0]       lut_data,
    output logic [N:0]         sample,
    output logic [VW-1:0]      sample_voice,
    output logic               sample_valid,
    output logic [MW-1:0]      mix,
    output logic               mix_valid,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_MIXOUT} state_t;

    state_t               state_q, state_d;
    logic [VW-1:0]        vcnt_q, vcnt_d;
    logic [PHASE_W-1:0]   phase_q [VOICES];
    logic [PHASE_W-1:0]   phase_d [VOICES];
    logic [PHASE_W-1:0]   inc_q [VOICES];
    logic [PHASE_W-1:0]   inc_d [VOICES];
    logic [PHASE_W-1:0]   sh_inc_q [VOICES];
    logic [PHASE_W-1:0]   sh_inc_d [VOICES];
    logic [VOICES-1:0]    en_q, en_d, sh_en_q, sh_en_d;
    logic [N:0]           lut_addr_q, lut_addr_d;
    logic                 iss_valid_q, iss_valid_d;
    logic [VW-1:0]        iss_voice_q, iss_voice_d;
    logic [1:0]           iss_quad_q, iss_quad_d;
    logic                 iss_en_q, iss_en_d;
    logic                 smp_valid_q, smp_valid_d;
    logic [VW-1:0]        smp_voice_q, smp_voice_d;
    logic [1:0]           smp_quad_q, smp_quad_d;
    logic                 smp_en_q, smp_en_d;
    logic [MW-1:0]        acc_q, acc_d, mix_q, mix_d;
    logic                 mix_valid_q, mix_valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic [VW-1:0]        nv;
    logic [N:0]           sample_w;

    // Odd quadrants mirror the angle; a=0 there addresses the table peak 2^N.
    function automatic logic [N:0] t4_of(input logic [N+1:0] hp);
        if (hp[N]) t4_of = {1'b1, {N{1'b0}}} - {1'b0, hp[N-1:0]};
        else       t4_of = {1'b0, hp[N-1:0]};
    endfunction

    always_comb begin
        if (!smp_valid_q)     sample_w = '0;
        else if (!smp_en_q)   sample_w = {1'b1, {N{1'b0}}};
        else if (smp_quad_q[1]) sample_w = {1'b0, ~lut_data};
        else                  sample_w = {1'b1, lut_data};
    end

    always_comb begin
        state_d     = state_q;
        vcnt_d      = vcnt_q;
        phase_d     = phase_q;
        inc_d       = inc_q;
        en_d        = en_q;
        sh_inc_d    = sh_inc_q;
        sh_en_d     = sh_en_q;
        lut_addr_d  = '0;
        iss_valid_d = 1'b0;
        iss_voice_d = '0;
        iss_quad_d  = '0;
        iss_en_d    = 1'b0;
        smp_valid_d = iss_valid_q;
        smp_voice_d = iss_voice_q;
        smp_quad_d  = iss_quad_q;
        smp_en_d    = iss_en_q;
        acc_d       = smp_valid_q ? acc_q + MW'(sample_w) : acc_q;
        mix_d       = mix_q;
        mix_valid_d = 1'b0;
        overrun_d   = tick && (state_q != S_IDLE);
        nv          = vcnt_q + 1'b1;

        if (cfg_we) begin
            inc_d[cfg_voice] = cfg_inc;
            en_d[cfg_voice]  = cfg_en;
        end

        unique case (state_q)
            S_IDLE: begin
                if (tick) begin
                    // Shadows take the post-write values so a same-cycle write joins this frame.
                    state_d     = S_ISSUE;
                    vcnt_d      = '0;
                    sh_inc_d    = inc_d;
                    sh_en_d     = en_d;
                    acc_d       = '0;
                    lut_addr_d  = t4_of(phase_q[0][PHASE_W-1 -: N+2]);
                    iss_valid_d = 1'b1;
                    iss_voice_d = '0;
                    iss_quad_d  = phase_q[0][PHASE_W-1 -: 2];
                    iss_en_d    = en_d[0];
                end
            end
            S_ISSUE: begin
                if (sh_en_q[vcnt_q])
                    phase_d[vcnt_q] = phase_q[vcnt_q] + sh_inc_q[vcnt_q];
                if (vcnt_q == VW'(VOICES - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    vcnt_d      = nv;
                    lut_addr_d  = t4_of(phase_q[nv][PHASE_W-1 -: N+2]);
                    iss_valid_d = 1'b1;
                    iss_voice_d = nv;
                    iss_quad_d  = phase_q[nv][PHASE_W-1 -: 2];
                    iss_en_d    = sh_en_q[nv];
                end
            end
            S_DRAIN: begin
                state_d     = S_MIXOUT;
                mix_d       = acc_d;
                mix_valid_d = 1'b1;
            end
            S_MIXOUT: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vcnt_q      <= '0;
            phase_q     <= '{default: '0};
            inc_q       <= '{default: '0};
            sh_inc_q    <= '{default: '0};
            en_q        <= '0;
            sh_en_q     <= '0;
            lut_addr_q  <= '0;
            iss_valid_q <= 1'b0;
            iss_voice_q <= '0;
            iss_quad_q  <= '0;
            iss_en_q    <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_voice_q <= '0;
            smp_quad_q  <= '0;
            smp_en_q    <= 1'b0;
            acc_q       <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vcnt_q      <= vcnt_d;
            phase_q     <= phase_d;
            inc_q       <= inc_d;
            sh_inc_q    <= sh_inc_d;
            en_q        <= en_d;
            sh_en_q     <= sh_en_d;
            lut_addr_q  <= lut_addr_d;
            iss_valid_q <= iss_valid_d;
            iss_voice_q <= iss_voice_d;
            iss_quad_q  <= iss_quad_d;
            iss_en_q    <= iss_en_d;
            smp_valid_q <= smp_valid_d;
            smp_voice_q <= smp_voice_d;
            smp_quad_q  <= smp_quad_d;
            smp_en_q    <= smp_en_d;
            acc_q       <= acc_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign lut_addr     = lut_addr_q;
    assign sample       = sample_w;
    assign sample_voice = smp_voice_q;
    assign sample_valid = smp_valid_q;
    assign mix          = mix_q;
    assign mix_valid    = mix_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Scoreboard bench for sine_voice_scheduler: a behavioural phase model queues
// expected addresses, samples and mixes; a negedge monitor pops and compares.
module tb_sine_voice_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_voice = '0;
    logic        cfg_en = 1'b0;
    logic [15:0] cfg_inc = '0;
    logic [7:0]  lut_addr;
    logic [6:0]  lut_data = '0;
    logic [7:0]  sample;
    logic [1:0]  sample_voice;
    logic        sample_valid;
    logic [9:0]  mix;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    sine_voice_scheduler #(.VOICES(4), .N(7), .PHASE_W(16)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_en(cfg_en), .cfg_inc(cfg_inc),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .sample(sample), .sample_voice(sample_voice), .sample_valid(sample_valid),
        .mix(mix), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Table stand-in: registered, returns the low 7 bits of the previous address.
    always @(posedge clk) lut_data <= lut_addr[6:0];

    typedef struct packed {
        logic [1:0] v;
        logic [7:0] addr;
        logic [7:0] smp;
    } exp_t;

    exp_t        exp_q[$];
    logic [9:0]  mixexp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] mph[4];
    logic [15:0] minc[4];
    logic        men[4];
    logic [7:0]  prev_addr = '0;

    function automatic logic [7:0] exp_addr(input logic [15:0] p);
        logic [6:0] a;
        a = p[13:7];
        if (p[14]) return 8'd128 - {1'b0, a};
        return {1'b0, a};
    endfunction

    function automatic logic [7:0] exp_sample(input logic [15:0] p, input logic en);
        logic [7:0] ad;
        logic [6:0] s;
        ad = exp_addr(p);
        s = ad[6:0];
        if (!en) return 8'h80;
        if (!p[15]) return {1'b1, s};
        return 8'd127 - {1'b0, s};
    endfunction

    task automatic push_frame();
        logic [9:0] sum;
        exp_t e;
        sum = '0;
        for (int v = 0; v < 4; v++) begin
            e.v = 2'(v);
            e.addr = exp_addr(mph[v]);
            e.smp = exp_sample(mph[v], men[v]);
            exp_q.push_back(e);
            sum = sum + {2'b00, e.smp};
            if (men[v]) mph[v] = mph[v] + minc[v];
        end
        mixexp_q.push_back(sum);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sample_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_sample voice=%0d got=%h want=none", sample_voice, sample);
            end else begin
                e = exp_q.pop_front();
                if ({sample_voice, prev_addr, sample} !== {e.v, e.addr, e.smp}) begin
                    n_fail++;
                    $display("FAIL sample got v=%0d addr=%h smp=%h want v=%0d addr=%h smp=%h",
                             sample_voice, prev_addr, sample, e.v, e.addr, e.smp);
                end
            end
        end
        if (mix_valid) begin
            n_checks++;
            if (mixexp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_mix got=%h want=none", mix);
            end else if (mix !== mixexp_q[0]) begin
                n_fail++;
                $display("FAIL mix got=%h want=%h", mix, mixexp_q[0]);
                void'(mixexp_q.pop_front());
            end else begin
                void'(mixexp_q.pop_front());
            end
        end
        prev_addr <= lut_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mix();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mix_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mix_timeout got=none want=mix_valid");
        end
        step();
    endtask

    task automatic do_cfg(input int v, input bit en, input logic [15:0] inc);
        cfg_we = 1'b1;
        cfg_voice = 2'(v);
        cfg_en = en;
        cfg_inc = inc;
        step();
        cfg_we = 1'b0;
        men[v] = en;
        minc[v] = inc;
    endtask

    task automatic run_frame(input bit wr, input int v, input bit en, input logic [15:0] inc);
        tick = 1'b1;
        if (wr) begin
            cfg_we = 1'b1;
            cfg_voice = 2'(v);
            cfg_en = en;
            cfg_inc = inc;
            men[v] = en;
            minc[v] = inc;
        end
        push_frame();
        step();
        tick = 1'b0;
        cfg_we = 1'b0;
        wait_mix();
    endtask

    task automatic model_clear();
        for (int v = 0; v < 4; v++) begin
            mph[v] = '0;
            minc[v] = '0;
            men[v] = 1'b0;
        end
    endtask

    task automatic test_reset();
        model_clear();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        n_checks++;
        if ({lut_addr, sample, sample_voice, mix} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_data got=%h want=0", {lut_addr, sample, sample_voice, mix});
        end
        n_checks++;
        if ({sample_valid, mix_valid, busy, overrun} !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=0000", {sample_valid, mix_valid, busy, overrun});
        end
        step();
        rst = 1'b0;
        step();
        tick = 1'b1;
        push_frame();
        step();
        tick = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_T+%0d got=%b want=1", k, busy);
            end
            n_checks++;
            if (mix_valid !== (k == 6)) begin
                n_fail++;
                $display("FAIL mix_valid_T+%0d got=%b want=%b", k, mix_valid, k == 6);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({busy, mix_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_T+7 got=%b want=00", {busy, mix_valid});
        end
        step();
    endtask

    task automatic test_single_voice();
        do_cfg(0, 1'b1, 16'h0100);
        repeat (3) run_frame(1'b0, 0, 1'b0, 16'h0);
    endtask

    task automatic test_quadrants();
        do_cfg(1, 1'b1, 16'h4000);
        repeat (5) run_frame(1'b0, 0, 1'b0, 16'h0);
    endtask

    task automatic test_same_cycle_cfg();
        run_frame(1'b1, 2, 1'b1, 16'h8080);
        run_frame(1'b0, 0, 1'b0, 16'h0);
    endtask

    task automatic test_overrun();
        tick = 1'b1;
        push_frame();
        step();
        tick = 1'b0;
        step();
        cfg_we = 1'b1;
        cfg_voice = 2'd3;
        cfg_en = 1'b1;
        cfg_inc = 16'h6000;
        step();
        cfg_we = 1'b0;
        men[3] = 1'b1;
        minc[3] = 16'h6000;
        tick = 1'b1;
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_T+3 got=%b want=0", overrun);
        end
        step();
        tick = 1'b0;
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_T+4 got=%b want=1", overrun);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_T+5 got=%b want=0", overrun);
        end
        wait_mix();
        repeat (3) run_frame(1'b0, 0, 1'b0, 16'h0);
    endtask

    task automatic test_back_to_back();
        tick = 1'b1;
        push_frame();
        step();
        tick = 1'b0;
        repeat (5) step();
        tick = 1'b1;
        @(negedge clk);
        step();
        tick = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({overrun, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL mixout_tick got=%b want=10", {overrun, busy});
        end
        step();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mixout_tick_ignored got=%b want=0", busy);
        end
        step();
        repeat (2) run_frame(1'b0, 0, 1'b0, 16'h0);
    endtask

    task automatic test_reset_mid();
        tick = 1'b1;
        push_frame();
        step();
        tick = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        mixexp_q.delete();
        model_clear();
        @(negedge clk);
        n_checks++;
        if ({lut_addr, sample, sample_voice, mix} !== 28'h0) begin
            n_fail++;
            $display("FAIL midrst_data got=%h want=0", {lut_addr, sample, sample_voice, mix});
        end
        n_checks++;
        if ({sample_valid, mix_valid, busy, overrun} !== 4'h0) begin
            n_fail++;
            $display("FAIL midrst_flags got=%b want=0000", {sample_valid, mix_valid, busy, overrun});
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if ({sample_valid, mix_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL midrst_quiet got=%b want=00", {sample_valid, mix_valid});
            end
        end
        step();
        do_cfg(0, 1'b1, 16'h0300);
        repeat (2) run_frame(1'b0, 0, 1'b0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_single_voice();
        test_quadrants();
        test_same_cycle_cfg();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        repeat (3) step();
        n_checks++;
        if (exp_q.size() != 0 || mixexp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover got=%0d/%0d want=0/0", exp_q.size(), mixexp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sine_voice_scheduler.md
# sine_voice_scheduler

Time-multiplexes one shared quarter-wave sine lookup table among `VOICES` independent phase-accumulator voices. On each sample strobe it walks the voices in order and advances each enabled voice's phase. It issues one table address per cycle and rebuilds the full-wave sample from the quadrant. It outputs per-voice samples plus their sum. It sits between the register/config path and the quarter-wave table, replacing one free-running accumulator per table instance.

## Interface
Parameters:
- `VOICES`, 4: number of voices; power of two, 2..16.
- `N`, 7: quarter-table resolution; angle is N bits, table data N bits, sample N+1 bits.
- `PHASE_W`, 16: phase accumulator width; must be ≥ N+2.

Ports:
- `clk`, in, 1: single clock, all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `tick`, in, 1: sample strobe, one-cycle pulse starting a frame.
- `cfg_we`, in, 1: config write strobe.
- `cfg_voice`, in, log2(VOICES): voice index for the write.
- `cfg_en`, in, 1: voice enable value to write.
- `cfg_inc`, in, PHASE_W: phase increment value to write.
- `lut_addr`, out, N+1: table index t4 (0..2^N).
- `lut_data`, in, N: table value; registered table, valid one cycle after `lut_addr`.
- `sample`, out, N+1: rebuilt sample of the voice in `sample_voice`.
- `sample_voice`, out, log2(VOICES): voice index of `sample`.
- `sample_valid`, out, 1: one-cycle qualifier for `sample`/`sample_voice`.
- `mix`, out, N+1+log2(VOICES): unsigned sum of all voice samples of the last frame.
- `mix_valid`, out, 1: one-cycle pulse when `mix` updates.
- `busy`, out, 1: high from the cycle after an accepted tick through the `mix_valid` cycle.
- `overrun`, out, 1: one-cycle pulse when a tick arrives while busy.

## Operation
- Per-voice state:
  - `phase[v]` (PHASE_W), working registers `inc[v]` and `en[v]`.
  - Shadow copies of `inc[v]` and `en[v]`, copied from the working registers at frame start.
- Config:
  - `cfg_we` writes `inc[cfg_voice]` and `en[cfg_voice]` in any state.
  - A write takes effect at the next frame start, never mid-frame.
  - A write in the same cycle as an accepted tick is included in that frame.
- FSM states:
  - IDLE: a tick accepted here goes to ISSUE, with voice counter = 0 and the shadow registers loaded.
  - ISSUE: one voice per cycle. `lut_addr` is driven from voice v's current phase. If `en[v]` is set, phase[v] <= phase[v] + inc[v] mod 2^PHASE_W; otherwise the phase holds. After voice VOICES-1, go to DRAIN.
  - DRAIN: one cycle to receive the last table value, then go to MIXOUT.
  - MIXOUT: pulse `mix_valid`, then go to IDLE.
- Address decode from the pre-increment phase p:
  - quadrant q = p[PHASE_W-1:PHASE_W-2]; angle a = p[PHASE_W-3:PHASE_W-2-N].
  - q even: t4 = {0,a}. q odd: t4 = 2^N − a, so a=0 gives 2^N.
- Sample rebuild, using the quadrant and enable delayed one cycle alongside `lut_data` s:
  - q=0 or 1: {1, s}.
  - q=2 or 3: {0, (2^N−1) − s}.
  - Disabled voice: {1, N zeros} (midscale) regardless of `lut_data`; `lut_addr` is still driven normally.
- Mix:
  - Accumulator is cleared at frame start and adds each sample as it becomes valid.
  - Result is copied to `mix` in MIXOUT. Widths guarantee no overflow.
- `tick` while busy (ISSUE, DRAIN, MIXOUT): ignored, `overrun` pulses, the frame continues unaffected.
- `rst` mid-frame aborts immediately: state IDLE, the partial frame is discarded, no `mix_valid`.

## Timing
- Accepted tick sampled at edge T:
  - `lut_addr` holds voice v's index during cycle T+1+v.
  - `sample_valid` is high for voice v in cycle T+2+v.
  - `mix_valid` is high in cycle T+VOICES+2.
- Frame length is VOICES+2 cycles. A tick in cycle T+VOICES+2 (MIXOUT) is an overrun; the earliest next accepted tick is in cycle T+VOICES+3.
- Updated phase is visible to the next frame only.
- Reset values:
  - All phases, incs, enables and shadows 0.
  - `lut_addr`, `sample`, `sample_voice`, `mix`: 0.
  - `sample_valid`, `mix_valid`, `busy`, `overrun`: 0.
- Outputs are registered. `lut_addr` is 0 outside ISSUE.

## Test plan
Defaults VOICES=4, N=7, PHASE_W=16. The bench table model returns `lut_data` = low 7 bits of the previous `lut_addr`.
- Reset, then tick with no config → `lut_addr` 0,0,0,0; samples 0x80 ×4 in T+2..T+5; `mix`=0x200 at T+6; `busy` high T+1..T+6.
- Voice 0 enabled, inc=0x0100 → frame 1: addr 0, sample 0x80; frame 2: addr 2, sample 0x82; phase after frame 2 is 0x0200.
- Voice 1 inc=0x4000, enabled → successive frames give addr 0 (q0), 0x80 (q1, a=0), 0 (q2, sample 0x7F), 0x80 (q3, sample 0x7F); phase wraps to 0 after 4 frames.
- Voice 2 phase reaches 0x8080 (inc=0x8080, one frame) → q2 a=1, addr 1, sample 0x7E.
- Tick again at T+3, and a cfg write to voice 3 at T+2 → `overrun` pulses at T+4; frame unchanged; voice 3's new setting appears only in the next frame.
- `rst` asserted at T+3 → no further `sample_valid`, no `mix_valid`; all outputs 0 next cycle; the next tick starts a clean frame with phases 0.
